// File: rtl/uart_tx_frame_gen_pkg.sv
// Shared UART definitions: TX state encodings, parity-type codes and line levels.
// The RX checkers import the same parity and line-level constants.
package uart_tx_frame_gen_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_START  = S_START,
        ST_DATA   = S_DATA,
        ST_PARITY = S_PARITY,
        ST_STOP   = S_STOP
    } tx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_frame_gen_if.sv
// Parallel-side request and serial-side line of the UART transmitter.
// master = TX FIFO read side driving the request; slave = the transmitter.
interface uart_tx_frame_gen_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  Busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        input  TX_OUT, Busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        output TX_OUT, Busy
    );
endinterface

// File: rtl/uart_tx_frame_gen_parity_calc.sv
// Parity of a payload word, even or odd as selected by par_typ.
// Latency: combinational; the caller registers the result.
// Backpressure: none.
module uart_tx_parity_calc
    import uart_tx_frame_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  par_typ,
    output logic                  par_bit
);
    assign par_bit = (^p_data) ^ (par_typ == PAR_ODD);
endmodule

// File: rtl/uart_tx_frame_gen.sv
// UART TX framer: start, DATA_WIDTH bits LSB first, optional parity, one stop bit.
// Latency: start bit appears on the accept edge; one bit per CLK.
// Backpressure: Data_Valid is taken only in IDLE or on the STOP cycle; Busy marks frame cycles.
module uart_tx_frame_gen
    import uart_tx_frame_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic          CLK,
    input  logic          RST,
    uart_tx_frame_gen_if.slave tx
);
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    tx_state_t             state;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic                  par_q;
    logic [CNT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      bit_cnt_nxt;
    logic                  tx_q;
    logic                  busy_q;
    logic                  par_calc;

    uart_tx_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .p_data  (tx.P_DATA),
        .par_typ (tx.PAR_TYP),
        .par_bit (par_calc)
    );

    assign bit_cnt_nxt = bit_cnt + 1'b1;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= ST_IDLE;
            data_q   <= '0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            bit_cnt  <= '0;
            tx_q     <= IDLE_LEVEL;
            busy_q   <= 1'b0;
        end else begin
            case (state)
                // STOP is the last frame cycle, so it accepts just like IDLE to allow back-to-back frames.
                ST_IDLE, ST_STOP: begin
                    if (tx.Data_Valid) begin
                        state    <= ST_START;
                        data_q   <= tx.P_DATA;
                        par_en_q <= tx.PAR_EN;
                        par_q    <= par_calc;
                        bit_cnt  <= '0;
                        tx_q     <= START_BIT;
                        busy_q   <= 1'b1;
                    end else begin
                        state  <= ST_IDLE;
                        tx_q   <= IDLE_LEVEL;
                        busy_q <= 1'b0;
                    end
                end
                ST_START: begin
                    state   <= ST_DATA;
                    bit_cnt <= '0;
                    tx_q    <= data_q[0];
                end
                ST_DATA: begin
                    if (bit_cnt == LAST_BIT) begin
                        if (par_en_q) begin
                            state <= ST_PARITY;
                            tx_q  <= par_q;
                        end else begin
                            state <= ST_STOP;
                            tx_q  <= STOP_BIT;
                        end
                    end else begin
                        bit_cnt <= bit_cnt_nxt;
                        tx_q    <= data_q[bit_cnt_nxt];
                    end
                end
                ST_PARITY: begin
                    state <= ST_STOP;
                    tx_q  <= STOP_BIT;
                end
                default: begin
                    state  <= ST_IDLE;
                    tx_q   <= IDLE_LEVEL;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign tx.TX_OUT = tx_q;
    assign tx.Busy   = busy_q;
endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Directed bench for uart_tx_frame_gen: per-cycle expected line/Busy values are queued
// by the stimulus and popped by an independent monitor after every rising edge.
module tb_uart_tx_frame_gen;
    import uart_tx_frame_gen_pkg::*;

    logic CLK = 1'b0;
    logic RST;

    uart_tx_frame_gen_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_frame_gen #(
        .DATA_WIDTH (8)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .tx  (bus)
    );

    always #5 CLK = ~CLK;

    logic [1:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int mon_cyc = 0;

    // Monitor: one queued {TX_OUT, Busy} expectation per rising edge.
    initial begin
        logic [1:0] e;
        forever begin
            @(posedge CLK);
            #1;
            mon_cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.TX_OUT !== e[1] || bus.Busy !== e[0]) begin
                    errors++;
                    $display("FAIL line cyc %0d: TX_OUT=%b Busy=%b, required TX_OUT=%b Busy=%b",
                             mon_cyc, bus.TX_OUT, bus.Busy, e[1], e[0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic rst_v, input logic dv, input logic [7:0] d,
                         input logic pen, input logic ptyp, input logic etx, input logic eb);
        @(negedge CLK);
        RST            = rst_v;
        bus.Data_Valid = dv;
        bus.P_DATA     = d;
        bus.PAR_EN     = pen;
        bus.PAR_TYP    = ptyp;
        exp_q.push_back({etx, eb});
    endtask

    task automatic idle(input int n, input logic rst_v);
        for (int i = 0; i < n; i++)
            drive(rst_v, 1'b0, 8'h00, 1'b0, 1'b0, IDLE_LEVEL, 1'b0);
    endtask

    // exp holds the hand-derived line value for each frame cycle, start bit first.
    task automatic send(input logic [7:0] d, input logic pen, input logic ptyp,
                        input string exp, input bit glitch, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            logic g;
            g = glitch && (i >= 2) && (i <= 5);
            drive(1'b1, (i == 0) || g, g ? 8'hFF : d, g ? 1'b1 : pen, g ? ~ptyp : ptyp,
                  exp[i] == "1", 1'b1);
        end
    endtask

    initial begin
        RST            = 1'b0;
        bus.Data_Valid = 1'b0;
        bus.P_DATA     = 8'h00;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;

        idle(3, 1'b0);
        idle(20, 1'b1);

        send(8'hA5, 1'b0, PAR_EVEN, "0101001011", 1'b0, 10);
        idle(2, 1'b1);
        send(8'hA5, 1'b1, PAR_EVEN, "01010010101", 1'b0, 11);
        idle(2, 1'b1);
        send(8'hA5, 1'b1, PAR_ODD, "01010010111", 1'b0, 11);
        idle(2, 1'b1);
        send(8'h00, 1'b1, PAR_ODD, "00000000011", 1'b0, 11);
        idle(2, 1'b1);

        // Request and payload/config changes during data bits must not disturb the frame.
        send(8'h3C, 1'b0, PAR_EVEN, "0001111001", 1'b1, 10);
        idle(3, 1'b1);

        // Back-to-back: second request lands on the stop-bit edge.
        send(8'hA5, 1'b0, PAR_EVEN, "0101001011", 1'b0, 10);
        send(8'h55, 1'b0, PAR_EVEN, "0101010101", 1'b0, 10);
        idle(2, 1'b1);

        // Reset while data bit 4 of a 0x00 frame is on the line.
        send(8'h00, 1'b0, PAR_EVEN, "000000", 1'b0, 6);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        checks++;
        if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: TX_OUT=%b Busy=%b, required TX_OUT=1 Busy=0",
                     bus.TX_OUT, bus.Busy);
        end
        idle(2, 1'b0);
        idle(2, 1'b1);
        send(8'h81, 1'b0, PAR_EVEN, "0100000011", 1'b0, 10);
        idle(3, 1'b1);

        @(posedge CLK);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_frame_gen.md
Name: uart_tx_frame_gen

Overview:
UART transmitter: accepts a parallel byte with a valid strobe and serialises it onto the TX line, one bit per CLK cycle (CLK is the TX baud clock).
- Frame format: start bit (0), DATA_WIDTH data bits LSB first, optional parity bit, one stop bit (1).
- Counterpart of the UART RX path; the RX side's start, parity and stop checks apply to frames this block produces.
- Sits between the TX FIFO read side and the pad.

Parameters:
DATA_WIDTH, 8, width of the parallel payload and number of data bits per frame.

Ports:
CLK  input  1  UART TX clock, one tick per transmitted bit.
RST  input  1  asynchronous active-low reset (synchronised upstream).
P_DATA  input  DATA_WIDTH  parallel payload; sampled only on an accept edge.
Data_Valid  input  1  request to send P_DATA; ignored unless the block can accept.
PAR_EN  input  1  1 = parity bit inserted after the data bits.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
TX_OUT  output  1  serial line, registered; idles high.
Busy  output  1  registered; high while a frame is on the line.

Behaviour:
- Reset (RST low, async): state IDLE, TX_OUT=1, Busy=0, bit counter=0, data and parity registers cleared. A reset mid-frame aborts the frame and forces the line high immediately, with no glitch to 0.
- States: IDLE, START, DATA, PARITY, STOP.
- Accept edge: a rising CLK edge with Data_Valid=1 while in IDLE, or in STOP (last cycle of the current frame).
  - On accept: latch P_DATA, PAR_EN and PAR_TYP.
  - Parity = XOR-reduce(P_DATA) when PAR_TYP=0; its inverse when PAR_TYP=1.
  - Next state START, TX_OUT=0, Busy=1.
- Data_Valid in START, DATA or PARITY is ignored; the latched payload and config never change mid-frame.
- START lasts 1 cycle, then DATA.
- DATA lasts DATA_WIDTH cycles; TX_OUT = data[i], i = 0..DATA_WIDTH-1; counter width = clog2(DATA_WIDTH).
- After the last data bit: PARITY if the latched PAR_EN=1, otherwise STOP.
- PARITY lasts 1 cycle with TX_OUT = latched parity, then STOP.
- STOP lasts 1 cycle with TX_OUT=1.
  - If Data_Valid=1 at the edge ending STOP: back-to-back frame, go straight to START, Busy stays 1, no idle gap.
  - Otherwise go to IDLE: TX_OUT=1, Busy=0.
- Latency: TX_OUT drives the start bit on the accept edge itself, i.e. 0 cycles after the accept edge.
- Frame length: DATA_WIDTH+2 cycles without parity, DATA_WIDTH+3 with parity (10/11 at default).
- Busy is high for exactly the frame cycles, and continuously high across back-to-back frames.
- Outputs come directly from flops; no combinational path from inputs to TX_OUT or Busy.
- Illegal or unreached state encodings recover to IDLE with TX_OUT=1.

Decomposition:
- Shared UART package:
  - state encoding localparams;
  - PAR_TYP encodings (EVEN=0, ODD=1);
  - line-level constants (START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1).
  The RX checkers use the same PAR_TYP and line-level constants.
- One natural sub-module: uart_tx_parity_calc. It is combinational (P_DATA, PAR_TYP -> parity bit) and its result is registered in this block on the accept edge.
- The FSM, bit counter and output mux stay in the top.

Test Plan:
- Reset with no Data_Valid -> TX_OUT=1, Busy=0 for 20 cycles.
- P_DATA=0xA5, PAR_EN=0, one-cycle Data_Valid -> TX_OUT = 0,1,0,1,0,0,1,0,1,1 over 10 cycles. Busy=1 for exactly those 10 cycles, then TX_OUT=1, Busy=0.
- P_DATA=0xA5, PAR_EN=1:
  - PAR_TYP=0 -> parity bit (cycle 10) = 0;
  - PAR_TYP=1 -> parity bit = 1;
  - 11-cycle frame, stop in cycle 11.
  - Also P_DATA=0x00 with odd parity -> parity bit = 1.
- P_DATA changed to 0xFF and Data_Valid pulsed during the data bits of a 0x3C frame -> 0x3C frame unaffected, no second frame starts.
- Back-to-back: Data_Valid high on the stop-bit edge with P_DATA=0x55 -> the next cycle is start bit 0, no idle gap, Busy never drops.
- RST asserted during data bit 4 of a 0x00 frame -> TX_OUT=1 and Busy=0 immediately. After release, a new 0x81 frame transmits correctly.
